mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_ctrl_cnt.sv | 31 +++
 rtl/mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the mem_ctrl block: FSM state encoding, rw encodings,
// enable/disable levels, parameter defaults and the terminal-count helper.
package mem_ctrl_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int READ_LAT_DEF   = 4;
    localparam int WR_TIMEOUT_DEF = 15;

    // Shared latency/timeout counter width; READ_LAT and WR_TIMEOUT stay <= 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Terminal count for a phase lasting n cycles (counter starts at zero)
    function automatic logic [CNT_W-1:0] tc_of(input int n);
        return CNT_W'(n - 32'sd1);
    endfunction

endpackage

// File: rtl/mem_ctrl_cnt.sv
// Clearable up-counter with terminal-count compare, shared by the read
// latency path and the write timeout path of mem_ctrl.
module mem_ctrl_cnt
    import mem_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear takes priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == tc_val);

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding-request memory controller between a cache and a memory
// model. Reads complete after a fixed READ_LAT cycles; writes complete on
// mem_complete. Optional feature macro: MEM_CTRL_TIMEOUT_EN enables the write
// timeout (abort to ACK after WR_TIMEOUT WRITE cycles, sticky timeout_err).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int READ_LAT   = READ_LAT_DEF,
    parameter int WR_TIMEOUT = WR_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic        req_rw,
    input  logic [25:0] req_addr,
    input  logic [31:0] req_wd,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rd,
    output logic        mem_rw,
    output logic [25:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    input  logic        mem_complete,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] RD_TC = tc_of(READ_LAT);
    localparam logic [CNT_W-1:0] WR_TC = tc_of(WR_TIMEOUT);

    state_t           state_r;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic             cnt_tc_s;
    logic [CNT_W-1:0] cnt_tc_val_s;
    logic             timeout_hit_s;

    assign cnt_tc_val_s = (state_r == ST_WRITE) ? WR_TC : RD_TC;

    // Counter control: clear when a request is accepted, count while waiting
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        case (state_r)
            ST_IDLE:  cnt_clr_s = req_en;
            ST_READ:  cnt_inc_s = 1'b1;
`ifdef MEM_CTRL_TIMEOUT_EN
            ST_WRITE: cnt_inc_s = 1'b1;
`else
            ST_WRITE: cnt_inc_s = 1'b0;
`endif
            ST_ACK:   cnt_inc_s = 1'b0;
            default:  cnt_inc_s = 1'b0;
        endcase
    end

    mem_ctrl_cnt u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_s),
        .inc    (cnt_inc_s),
        .tc_val (cnt_tc_val_s),
        .tc     (cnt_tc_s)
    );

`ifdef MEM_CTRL_TIMEOUT_EN
    logic timeout_err_r;

    assign timeout_hit_s = (state_r == ST_WRITE) && !mem_complete && cnt_tc_s;

    // Sticky write-timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_r <= DISABLE;
        end else if (timeout_hit_s) begin
            timeout_err_r <= ENABLE;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = DISABLE;
`endif

    // Main FSM with registered busy/ack/rd and latched memory-side request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            ack      <= 1'b0;
            rd       <= 32'h0000_0000;
            mem_rw   <= RW_READ;
            mem_addr <= 26'h000_0000;
            mem_wd   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack <= 1'b0;
                    if (req_en) begin
                        mem_addr <= req_addr;
                        mem_wd   <= req_wd;
                        mem_rw   <= req_rw;
                        busy     <= 1'b1;
                        state_r  <= (req_rw == RW_READ) ? ST_READ : ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (cnt_tc_s) begin
                        rd      <= mem_rd;
                        ack     <= 1'b1;
                        state_r <= ST_ACK;
                    end
                end
                ST_WRITE: begin
                    // Completion wins over a timeout landing in the same cycle
                    if (mem_complete || timeout_hit_s) begin
                        ack     <= 1'b1;
                        mem_rw  <= RW_READ;
                        state_r <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack     <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack     <= 1'b0;
                    busy    <= 1'b0;
                    mem_rw  <= RW_READ;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of transactions plus hand-written
// corner sequences; expected acks are queued at drive time and popped by an
// ack monitor. Build with MEM_CTRL_TIMEOUT_EN to exercise the write timeout.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int RL    = 4;
    localparam int WR_TO = 15;

    typedef struct {
        logic        rw;
        logic [25:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          wdel;
        logic        stray;
    } vec_t;

    typedef struct {
        int          ack_cyc;
        logic [31:0] rd;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst, req_en, req_rw, stray;
    logic [25:0] req_addr;
    logic [31:0] req_wd, mem_rd;
    logic        busy, ack, mem_rw, mem_complete, timeout_err;
    logic [31:0] rd, mem_wd;
    logic [25:0] mem_addr;

    int   cyc = 0;
    int   wr_cnt = 0;
    int   wr_delay = -1;
    int   checks = 0;
    int   errors = 0;
    int   ack_count = 0;
    int   ack_prev = 0;
    int   ack_last = 0;
    logic [31:0] last_rd = 32'h0;
    sb_t  sbq[$];
    vec_t vecs[6];

    mem_ctrl #(.READ_LAT(RL), .WR_TIMEOUT(WR_TO)) dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_rw(req_rw),
        .req_addr(req_addr), .req_wd(req_wd), .busy(busy), .ack(ack),
        .rd(rd), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_complete(mem_complete), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: strobe mem_complete wr_delay cycles into a write
    always @(posedge clk) begin
        if (mem_rw == RW_WRITE) wr_cnt <= wr_cnt + 1;
        else                    wr_cnt <= 0;
    end
    assign mem_complete = stray |
        ((mem_rw == RW_WRITE) && (wr_delay >= 0) && (wr_cnt == wr_delay));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ack monitor: every ack must match the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (ack === 1'b1) begin
            ack_count++;
            ack_prev = ack_last;
            ack_last = cyc;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: got ack=1 expected ack=0 (cycle %0d)", cyc);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("ack_cycle", cyc, e.ack_cyc);
                chk("rd", rd, e.rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sbq.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_pending", sbq.size(), 32'd0);
        sbq.delete();
    endtask

    task automatic push_exp(input int ack_cyc, input logic [31:0] rdv);
        sb_t e;
        e.ack_cyc = ack_cyc;
        e.rd = rdv;
        sbq.push_back(e);
    endtask

    task automatic do_txn(input vec_t v);
        mem_rd = v.mrd;
        wr_delay = v.wdel;
        req_en = 1'b1; req_rw = v.rw; req_addr = v.addr; req_wd = v.wd;
        if (v.rw == RW_READ) last_rd = v.mrd;
        push_exp(cyc + 1 + ((v.rw == RW_READ) ? RL : v.wdel + 1), last_rd);
        tick();
        req_en = 1'b0;
        stray = v.stray;
        chk("busy_rise", busy, 32'd1);
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_wd", mem_wd, v.wd);
        chk("mem_rw_busy", mem_rw, v.rw);
        drain(40);
        stray = 1'b0;
        tick();
        chk("busy_fall", busy, 32'd0);
        chk("ack_fall", ack, 32'd0);
        chk("mem_rw_idle", mem_rw, RW_READ);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0;
        vec_t v;
        vecs[0] = '{RW_READ,  26'h0000010, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0};
        vecs[1] = '{RW_WRITE, 26'h0000020, 32'h1234_5678, 32'h0000_0000, 3, 1'b0};
        vecs[2] = '{RW_READ,  26'h3FFFFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b1};
        vecs[3] = '{RW_WRITE, 26'h0000000, 32'hFFFF_FFFF, 32'h1111_1111, 0, 1'b0};
        vecs[4] = '{RW_READ,  26'h1234567, 32'h0000_0000, 32'hA5A5_A5A5, 0, 1'b1};
        vecs[5] = '{RW_WRITE, 26'h2AAAAAA, 32'h0000_0000, 32'h2222_2222, 7, 1'b0};

        rst = 1'b1; req_en = 1'b1; req_rw = RW_WRITE; req_addr = 26'h1;
        req_wd = 32'h9; mem_rd = 32'h0; stray = 1'b0;
        tick();
        tick();
        req_en = 1'b0;
        chk("rst_busy", busy, 32'd0);
        chk("rst_ack", ack, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_mem_rw", mem_rw, RW_READ);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_timeout_err", timeout_err, 32'd0);
        rst = 1'b0;
        tick();

        // mem_complete in IDLE must do nothing
        acks0 = ack_count;
        stray = 1'b1;
        repeat (4) tick();
        stray = 1'b0;
        chk("idle_complete_busy", busy, 32'd0);
        chk("idle_complete_acks", ack_count - acks0, 32'd0);

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Back-to-back reads: second ack six cycles after the first
        v = '{RW_READ, 26'h0000100, 32'h0, 32'h0BAD_CAFE, 0, 1'b0};
        do_txn(v);
        v = '{RW_READ, 26'h0000104, 32'h0, 32'h600D_F00D, 0, 1'b0};
        do_txn(v);
        chk("b2b_spacing", ack_last - ack_prev, RL + 2);

        // Request while busy is ignored
        acks0 = ack_count;
        mem_rd = 32'hCAFE_F00D; req_wd = 32'h0;
        req_en = 1'b1; req_rw = RW_READ; req_addr = 26'h0000010;
        last_rd = 32'hCAFE_F00D;
        push_exp(cyc + 1 + RL, last_rd);
        tick();
        req_en = 1'b0;
        tick();
        req_en = 1'b1; req_rw = RW_WRITE; req_addr = 26'h0000030; req_wd = 32'h55;
        tick();
        req_en = 1'b0;
        chk("busy_req_addr", mem_addr, 32'h10);
        chk("busy_req_rw", mem_rw, RW_READ);
        chk("busy_req_wd", mem_wd, 32'h0);
        drain(40);
        repeat (8) tick();
        chk("busy_req_acks", ack_count - acks0, 32'd1);
        chk("busy_req_idle", busy, 32'd0);

        // Reset two cycles into WRITE abandons the transaction
        wr_delay = -1;
        req_en = 1'b1; req_rw = RW_WRITE; req_addr = 26'h0000040; req_wd = 32'h99;
        tick();
        req_en = 1'b0;
        tick();
        chk("midwr_mem_rw", mem_rw, RW_WRITE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_rd = 32'h0;
        acks0 = ack_count;
        chk("midwr_busy", busy, 32'd0);
        chk("midwr_mem_rw_rst", mem_rw, RW_READ);
        chk("midwr_ack", ack, 32'd0);
        chk("midwr_rd", rd, 32'd0);
        repeat (20) tick();
        chk("midwr_no_ack", ack_count - acks0, 32'd0);

`ifdef MEM_CTRL_TIMEOUT_EN
        // Write with no completion aborts after WR_TO WRITE cycles
        wr_delay = -1;
        req_en = 1'b1; req_rw = RW_WRITE; req_addr = 26'h0000050; req_wd = 32'h77;
        push_exp(cyc + 1 + WR_TO, last_rd);
        tick();
        req_en = 1'b0;
        chk("to_flag_early", timeout_err, 32'd0);
        drain(40);
        chk("to_flag_set", timeout_err, 32'd1);
        tick();
        chk("to_busy", busy, 32'd0);
        v = '{RW_READ, 26'h0000060, 32'h0, 32'h3333_3333, 0, 1'b0};
        do_txn(v);
        chk("to_flag_sticky", timeout_err, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_flag_rst", timeout_err, 32'd0);
`else
        // Without the timeout, a write waits indefinitely
        wr_delay = -1;
        acks0 = ack_count;
        req_en = 1'b1; req_rw = RW_WRITE; req_addr = 26'h0000050; req_wd = 32'h77;
        tick();
        req_en = 1'b0;
        repeat (30) tick();
        chk("nto_busy", busy, 32'd1);
        chk("nto_mem_rw", mem_rw, RW_WRITE);
        chk("nto_flag", timeout_err, 32'd0);
        chk("nto_no_ack", ack_count - acks0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("nto_rst_busy", busy, 32'd0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
